// File: rtl/vertex_projector.sv
// Perspective projection of one triangle: x' = x*D/z, y' = y*D/z for all three vertices.
// One shared multiplier feeds a bit-serial restoring divider; bypass passes x/y through.
module vertex_projector #(
  parameter int W = 32,
  parameter int D = 300
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           bypass,
  input  logic [9*W-1:0] in_vtx,
  output logic [6*W-1:0] out_xy,
  output logic           busy,
  output logic           done,
  output logic           div_err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic signed [W-1:0] D_W = W'(D);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, DIV, STORE, DONE} state_t;

  state_t state, state_nx;

  logic [9*W-1:0]        vtx_r;
  logic [2:0]            idx;
  logic [CW-1:0]         cnt;
  logic [W-1:0]          rem, quo, dvs;
  logic                  sign_r, dz_r;
  logic signed [W-1:0]   coord, zsel, num;
  logic [W-1:0]          num_mag, den_mag, result;
  logic [W:0]            rem_sh, diff;
  logic                  fits;

  // Slot idx walks x1,y1,x2,y2,x3,y3; each coordinate divides by its own vertex's z.
  always_comb begin
    coord = '0;
    zsel  = '0;
    case (idx)
      3'd0: begin coord = vtx_r[1*W-1:0*W]; zsel = vtx_r[3*W-1:2*W]; end
      3'd1: begin coord = vtx_r[2*W-1:1*W]; zsel = vtx_r[3*W-1:2*W]; end
      3'd2: begin coord = vtx_r[4*W-1:3*W]; zsel = vtx_r[6*W-1:5*W]; end
      3'd3: begin coord = vtx_r[5*W-1:4*W]; zsel = vtx_r[6*W-1:5*W]; end
      3'd4: begin coord = vtx_r[7*W-1:6*W]; zsel = vtx_r[9*W-1:8*W]; end
      3'd5: begin coord = vtx_r[8*W-1:7*W]; zsel = vtx_r[9*W-1:8*W]; end
      default: begin coord = '0; zsel = '0; end
    endcase
  end

  assign num     = coord * D_W;
  assign num_mag = num[W-1]  ? -num  : num;
  assign den_mag = zsel[W-1] ? -zsel : zsel;

  // Remainder stays below the divisor, so the borrow bit of diff is the compare result.
  assign rem_sh = {rem, quo[W-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign fits   = ~diff[W];
  assign result = dz_r ? '0 : (sign_r ? -quo : quo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = bypass ? DONE : LOAD;
      LOAD:    state_nx = MUL;
      MUL:     state_nx = DIV;
      DIV:     if (cnt == CW'(W-1)) state_nx = STORE;
      STORE:   state_nx = (idx == 3'd5) ? DONE : MUL;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vtx_r   <= '0;
      out_xy  <= '0;
      busy    <= 1'b0;
      div_err <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      sign_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          vtx_r   <= in_vtx;
          busy    <= 1'b1;
          div_err <= 1'b0;
          idx     <= '0;
          if (bypass)
            out_xy <= {in_vtx[8*W-1:7*W], in_vtx[7*W-1:6*W],
                       in_vtx[5*W-1:4*W], in_vtx[4*W-1:3*W],
                       in_vtx[2*W-1:1*W], in_vtx[1*W-1:0*W]};
        end
        MUL: begin
          sign_r <= num[W-1] ^ zsel[W-1];
          dz_r   <= (zsel == '0);
          quo    <= num_mag;
          dvs    <= den_mag;
          rem    <= '0;
          cnt    <= '0;
        end
        DIV: begin
          rem <= fits ? diff[W-1:0] : rem_sh[W-1:0];
          quo <= {quo[W-2:0], fits};
          cnt <= cnt + 1'b1;
        end
        STORE: begin
          out_xy[idx*W +: W] <= result;
          idx <= idx + 3'd1;
          if (dz_r) div_err <= 1'b1;
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_projector.sv
// Bench for vertex_projector: directed spec scenarios plus randomized jobs
// checked against an arithmetic reference model (wide signed divide, truncation toward zero).
module tb_vertex_projector;

  localparam int W = 32;
  localparam int D = 300;
  localparam int PROJ_LAT = 1 + 6 * (W + 2);

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           bypass = 1'b0;
  logic [9*W-1:0] in_vtx = '0;
  logic [6*W-1:0] out_xy;
  logic           busy, done, div_err;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vertex_projector #(.W(W), .D(D)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bypass(bypass),
    .in_vtx(in_vtx), .out_xy(out_xy), .busy(busy), .done(done), .div_err(div_err)
  );

  function automatic logic [9*W-1:0] mk(input int x1, y1, z1, x2, y2, z2, x3, y3, z3);
    return {z3, y3, x3, z2, y2, x2, z1, y1, x1};
  endfunction

  function automatic logic [6*W-1:0] mk6(input int x1, y1, x2, y2, x3, y3);
    return {y3, x3, y2, x2, y1, x1};
  endfunction

  // Reference: truncated W-bit product, then exact wide signed division (toward zero).
  function automatic void model(input logic [9*W-1:0] v, input bit byp,
                                output logic [6*W-1:0] e, output bit err);
    int c, z, num;
    longint q;
    err = 1'b0;
    e = '0;
    for (int k = 0; k < 6; k++) begin
      c = v[(3*(k/2) + k%2)*W +: W];
      z = v[(3*(k/2) + 2)*W +: W];
      if (byp) e[k*W +: W] = c;
      else begin
        num = c * D;
        if (z == 0) begin
          err = 1'b1;
          e[k*W +: W] = '0;
        end else begin
          q = longint'(num) / longint'(z);
          e[k*W +: W] = q[W-1:0];
        end
      end
    end
  endfunction

  // Waits for IDLE, issues start, scrambles inputs after acceptance, counts edges to done.
  task automatic run_job(input logic [9*W-1:0] v, input bit byp, output int lat);
    int guard;
    guard = 0;
    while (busy && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk);
    in_vtx = v;
    bypass = byp;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) in_vtx[i*W +: W] = $urandom;
    bypass = $urandom_range(0, 1);
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_xy !== '0) begin n_fail++; $display("FAIL reset_out_xy: got %h want 0", out_xy); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (div_err !== 1'b0) begin n_fail++; $display("FAIL reset_div_err: got %b want 0", div_err); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [6*W-1:0] exp;
    exp = mk6(30, 60, -60, 80, 0, 0);
    run_job(mk(10, 20, 100, -30, 40, 150, 0, 0, 300), 1'b0, lat);
    n_cmp++; if (lat != PROJ_LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, PROJ_LAT); end
    n_cmp++; if (out_xy !== exp) begin n_fail++; $display("FAIL basic_out_xy: got %h want %h", out_xy, exp); end
    n_cmp++; if (div_err !== 1'b0) begin n_fail++; $display("FAIL basic_div_err: got %b want 0", div_err); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 1", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_truncation();
    int lat;
    logic [6*W-1:0] exp;
    exp = mk6(5, -5, 300, 300, 300, 300);
    run_job(mk(7, -7, 400, 1, 1, 1, 1, 1, 1), 1'b0, lat);
    n_cmp++; if (out_xy !== exp) begin n_fail++; $display("FAIL trunc_out_xy: got %h want %h", out_xy, exp); end
    n_cmp++; if (div_err !== 1'b0) begin n_fail++; $display("FAIL trunc_div_err: got %b want 0", div_err); end
  endtask

  task automatic test_div_zero();
    int lat, guard;
    logic [6*W-1:0] exp;
    exp = mk6(30, 60, 0, 0, 500, -600);
    run_job(mk(10, 20, 100, -30, 40, 0, 5, -6, 3), 1'b0, lat);
    n_cmp++; if (out_xy !== exp) begin n_fail++; $display("FAIL dz_out_xy: got %h want %h", out_xy, exp); end
    n_cmp++; if (div_err !== 1'b1) begin n_fail++; $display("FAIL dz_div_err: got %b want 1", div_err); end
    guard = 0;
    while (busy && guard < 10) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (div_err !== 1'b1) begin n_fail++; $display("FAIL dz_sticky_idle: got %b want 1", div_err); end
    @(negedge clk);
    in_vtx = mk(10, 20, 100, -30, 40, 150, 0, 0, 300);
    start = 1'b1;
    bypass = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (div_err !== 1'b0) begin n_fail++; $display("FAIL dz_clear_on_start: got %b want 0", div_err); end
    guard = 0;
    while (!done && guard < 400) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (out_xy !== mk6(30, 60, -60, 80, 0, 0)) begin n_fail++; $display("FAIL dz_next_job: got %h", out_xy); end
  endtask

  task automatic test_extra_start();
    int e, dones, first, guard;
    logic [6*W-1:0] exp;
    exp = mk6(30, 60, -60, 80, 0, 0);
    guard = 0;
    while (busy && guard < 10) begin @(posedge clk); #1; guard++; end
    @(negedge clk);
    in_vtx = mk(10, 20, 100, -30, 40, 150, 0, 0, 300);
    bypass = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0; dones = 0; first = -1;
    while (e < 400) begin
      @(negedge clk);
      if (e + 1 == 3 || e + 1 == 100) begin
        start  = 1'b1;
        bypass = (e + 1 == 100);
        in_vtx = mk(1, 2, 0, 3, 4, 0, 5, 6, 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      e++;
      if (done) begin
        dones++;
        if (first < 0) first = e;
      end
    end
    n_cmp++; if (first != PROJ_LAT) begin n_fail++; $display("FAIL extra_latency: got %0d want %0d", first, PROJ_LAT); end
    n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL extra_done_count: got %0d want 1", dones); end
    n_cmp++; if (out_xy !== exp) begin n_fail++; $display("FAIL extra_out_xy: got %h want %h", out_xy, exp); end
    n_cmp++; if (div_err !== 1'b0) begin n_fail++; $display("FAIL extra_div_err: got %b want 0", div_err); end
  endtask

  task automatic test_reset_midjob();
    int e, dones, lat, guard;
    guard = 0;
    while (busy && guard < 10) begin @(posedge clk); #1; guard++; end
    @(negedge clk);
    in_vtx = mk(10, 20, 100, -30, 40, 150, 0, 0, 300);
    bypass = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (e = 1; e < 50; e++) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_xy !== '0) begin n_fail++; $display("FAIL midrst_out_xy: got %h want 0", out_xy); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d dones want 0", dones); end
    run_job(mk(10, 20, 100, -30, 40, 150, 0, 0, 300), 1'b0, lat);
    n_cmp++; if (lat != PROJ_LAT) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", lat, PROJ_LAT); end
    n_cmp++; if (out_xy !== mk6(30, 60, -60, 80, 0, 0)) begin n_fail++; $display("FAIL midrst_out_xy_after: got %h", out_xy); end
  endtask

  // done is high in the cycle right after the accepting edge, i.e. seen by the next edge.
  task automatic test_bypass();
    int lat;
    logic [6*W-1:0] exp;
    exp = mk6(10, 20, -30, 40, 0, 0);
    run_job(mk(10, 20, 100, -30, 40, 150, 0, 0, 300), 1'b1, lat);
    n_cmp++; if (lat != 0) begin n_fail++; $display("FAIL bypass_latency: got %0d want 0", lat); end
    n_cmp++; if (out_xy !== exp) begin n_fail++; $display("FAIL bypass_out_xy: got %h want %h", out_xy, exp); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bypass_busy_high: got %b want 1", busy); end
    n_cmp++; if (div_err !== 1'b0) begin n_fail++; $display("FAIL bypass_div_err: got %b want 0", div_err); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bypass_busy_low: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL bypass_done_low: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [9*W-1:0] v;
    logic [6*W-1:0] e;
    bit err;
    v = mk(-1000, 999, -7, 123456, -654321, 77, 2147483, -2147483, -300);
    for (int j = 0; j < 3; j++) begin
      model(v, (j == 1), e, err);
      run_job(v, (j == 1), lat);
      n_cmp++; if (lat != ((j == 1) ? 0 : PROJ_LAT)) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d", j, lat); end
      n_cmp++; if (out_xy !== e) begin n_fail++; $display("FAIL b2b_out_xy[%0d]: got %h want %h", j, out_xy, e); end
    end
  endtask

  task automatic test_random();
    int lat, sel;
    logic [9*W-1:0] v;
    logic [6*W-1:0] e;
    bit err, byp;
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < 9; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 4)       v[i*W +: W] = $urandom_range(0, 4000) - 2000;
        else if (sel < 7)  v[i*W +: W] = $urandom;
        else if (sel == 7) v[i*W +: W] = '0;
        else if (sel == 8) v[i*W +: W] = (i % 3 == 2) ? -1 : 32'h8000_0000;
        else               v[i*W +: W] = 1;
      end
      byp = ($urandom_range(0, 4) == 0);
      model(v, byp, e, err);
      run_job(v, byp, lat);
      n_cmp++; if (lat != (byp ? 0 : PROJ_LAT)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", j, lat, byp ? 0 : PROJ_LAT); end
      n_cmp++; if (out_xy !== e) begin n_fail++; $display("FAIL rand_out_xy[%0d]: got %h want %h", j, out_xy, e); end
      n_cmp++; if (div_err !== err) begin n_fail++; $display("FAIL rand_div_err[%0d]: got %b want %b", j, div_err, err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_div_zero();
    test_extra_start();
    test_reset_midjob();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
